// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline hazard logic.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hzd_state_t;

   localparam int unsigned REG_ZERO = 0;
   // Wide enough for MEM_LAT-2 with MEM_LAT up to 7.
   localparam int WAIT_W = 3;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline status in, stage-register controls and forwarded operands out.
import pipeline_pkg::*;

interface hazard_control_unit_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] rs_id, rt_id;
   logic              uses_rt_id;
   logic [REG_AW-1:0] rs_ex, rt_ex, wreg_ex;
   logic              regwrite_ex, memread_ex;
   logic [REG_AW-1:0] wreg_mem;
   logic              regwrite_mem, memread_mem;
   logic [REG_AW-1:0] wreg_wb;
   logic              regwrite_wb;
   logic              branch_taken_mem;
   logic [DATA_W-1:0] rs_data_ex, rt_data_ex, alu_result_mem, wb_data;

   logic              pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic              if_id_flush, id_ex_flush, ex_mem_flush;
   fwd_sel_t          forward_a, forward_b;
   logic [DATA_W-1:0] alu_in_a, fwd_rt_data;
   logic [CNT_W-1:0]  stall_cycles;

   modport slave (
      input  rs_id, rt_id, uses_rt_id, rs_ex, rt_ex, wreg_ex, regwrite_ex, memread_ex,
             wreg_mem, regwrite_mem, memread_mem, wreg_wb, regwrite_wb, branch_taken_mem,
             rs_data_ex, rt_data_ex, alu_result_mem, wb_data,
      output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
             if_id_flush, id_ex_flush, ex_mem_flush, forward_a, forward_b,
             alu_in_a, fwd_rt_data, stall_cycles
   );

   modport master (
      output rs_id, rt_id, uses_rt_id, rs_ex, rt_ex, wreg_ex, regwrite_ex, memread_ex,
             wreg_mem, regwrite_mem, memread_mem, wreg_wb, regwrite_wb, branch_taken_mem,
             rs_data_ex, rt_data_ex, alu_result_mem, wb_data,
      input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
             if_id_flush, id_ex_flush, ex_mem_flush, forward_a, forward_b,
             alu_in_a, fwd_rt_data, stall_cycles
   );
endinterface

// File: rtl/forward_select.sv
// Per-operand forwarding decode and operand mux; MEM beats WB, loads never forward from MEM.
module forward_select
   import pipeline_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] wreg_mem,
   input  logic              regwrite_mem,
   input  logic              memread_mem,
   input  logic [REG_AW-1:0] wreg_wb,
   input  logic              regwrite_wb,
   input  logic              force_rf,
   input  logic [DATA_W-1:0] rf_data,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] wb_data,
   output fwd_sel_t          sel,
   output logic [DATA_W-1:0] data
);
   logic mem_hit, wb_hit;

   assign mem_hit = regwrite_mem && !memread_mem &&
                    (wreg_mem != REG_AW'(REG_ZERO)) && (wreg_mem == src);
   assign wb_hit  = regwrite_wb && (wreg_wb != REG_AW'(REG_ZERO)) && (wreg_wb == src);

   always_comb begin
      sel = FWD_RF;
      if (!force_rf && (FWD_EN != 0)) begin
         if (mem_hit)
            sel = FWD_MEM;
         else if (wb_hit)
            sel = FWD_WB;
      end
   end

   always_comb begin
      data = rf_data;
      case (sel)
         FWD_MEM: data = mem_data;
         FWD_WB:  data = wb_data;
         default: data = rf_data;
      endcase
   end
endmodule

// File: rtl/hazard_control_unit.sv
// Hazard/forwarding controller: load-use and RAW stalls, branch flushes,
// multi-cycle load freeze and a saturating stall-cycle counter.
module hazard_control_unit
   import pipeline_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int MEM_LAT = 1,
   parameter int FWD_EN  = 1,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   hazard_control_unit_if.slave  hz
);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = (MEM_LAT > 1) ? WAIT_W'(MEM_LAT - 2) : '0;

   hzd_state_t        state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic [CNT_W-1:0]  stall_cycles_reg;
   logic              pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic              if_id_flush, id_ex_flush, ex_mem_flush;
   logic              load_use, raw_stall;

   logic [REG_AW-1:0] op_src [2];
   logic [DATA_W-1:0] op_rf  [2];
   logic [DATA_W-1:0] op_out [2];
   fwd_sel_t          op_sel [2];

   function automatic logic hits_id(input logic [REG_AW-1:0] dst);
      return (dst != REG_AW'(REG_ZERO)) &&
             ((dst == hz.rs_id) || (hz.uses_rt_id && (dst == hz.rt_id)));
   endfunction

   assign op_src[0] = hz.rs_ex;
   assign op_src[1] = hz.rt_ex;
   assign op_rf[0]  = hz.rs_data_ex;
   assign op_rf[1]  = hz.rt_data_ex;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         forward_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_sel (
            .src          (op_src[gi]),
            .wreg_mem     (hz.wreg_mem),
            .regwrite_mem (hz.regwrite_mem),
            .memread_mem  (hz.memread_mem),
            .wreg_wb      (hz.wreg_wb),
            .regwrite_wb  (hz.regwrite_wb),
            .force_rf     (reset),
            .rf_data      (op_rf[gi]),
            .mem_data     (hz.alu_result_mem),
            .wb_data      (hz.wb_data),
            .sel          (op_sel[gi]),
            .data         (op_out[gi])
         );
      end
   endgenerate

   // WB is not checked: the register file writes before it reads.
   assign load_use  = (FWD_EN != 0) && hz.memread_ex && hits_id(hz.wreg_ex);
   assign raw_stall = (FWD_EN == 0) &&
                      ((hz.regwrite_ex && hits_id(hz.wreg_ex)) ||
                       (hz.regwrite_mem && hits_id(hz.wreg_mem)));

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      mem_wb_write  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      if (reset) begin
         {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
         {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
      end else if (state_reg == MEM_WAIT) begin
         {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
         if (wait_cnt_reg == '0)
            state_next = RUN;
         else
            wait_cnt_next = wait_cnt_reg - 1'b1;
      end else begin
         // A taken branch squashes the stalled instruction, so it wins.
         if (hz.branch_taken_mem) begin
            {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
         end else if (load_use || raw_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
         if (hz.memread_mem && (MEM_LAT > 1)) begin
            state_next    = MEM_WAIT;
            wait_cnt_next = WAIT_LOAD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= RUN;
         wait_cnt_reg     <= '0;
         stall_cycles_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (!pc_write && (stall_cycles_reg != '1))
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
      end
   end

   assign hz.pc_write     = pc_write;
   assign hz.if_id_write  = if_id_write;
   assign hz.id_ex_write  = id_ex_write;
   assign hz.ex_mem_write = ex_mem_write;
   assign hz.mem_wb_write = mem_wb_write;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_flush  = id_ex_flush;
   assign hz.ex_mem_flush = ex_mem_flush;
   assign hz.forward_a    = op_sel[0];
   assign hz.forward_b    = op_sel[1];
   assign hz.alu_in_a     = op_out[0];
   assign hz.fwd_rt_data  = op_out[1];
   assign hz.stall_cycles = stall_cycles_reg;
endmodule
